dff16_chain31_shift: RTL and testbench
======================================

Name:
dff16_chain31_shift

Overview:
- 32-stage, 16-bit-wide shift-register pipeline with a common shift enable; every stage is exposed as its own output port.
- Used as a tapped delay line, e.g. a sample window feeding FIR- or correlator-style consumers that need all 32 most-recent valid samples in parallel.
- dout00 is the newest sample and dout31 the oldest; there are 31 links between dout00 and dout31.

Parameters:
- WIDTH, 16, data width of din and of every stage.
- Depth is fixed at 32 stages, because the output ports are individually enumerated.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  reset. Asynchronous and active-low: rst=0 clears all stages immediately.
- data_valid  input  1  shift enable, sampled at rising clk.
- din  input  WIDTH  sample entering stage 0.
- dout00 … dout31  output  WIDTH each  32 outputs, one per stage, each driven directly from its stage register; doutNN is stage NN.

Behaviour:
- Reset:
  - rst low → all 32 stage registers go to 0 asynchronously, independent of clk.
  - They stay 0 while rst is low.
  - On release, operation starts at the first rising edge where rst=1.
- Shift: at each rising clk with rst=1 and data_valid=1, all stages update together:
  - stage00 ← din
  - stageK ← stage(K-1) for K=1..31
  - The old stage31 value is discarded.
- Hold: at a rising clk with data_valid=0, every stage keeps its value. din is ignored.
- Latency:
  - A value captured from din at valid edge n appears on dout00 right after edge n.
  - It appears on doutK after the (K+1)-th valid edge counting edge n.
  - Invalid cycles stretch the delay; they do not drop data.
- Outputs are purely registered: no combinational path from din or data_valid to any dout.
- Reset asserted mid-stream clears the whole chain, including data in flight. Data is not resumed after reset.
- No overflow/underflow condition exists. The chain always holds exactly 32 words, initially zeros.
- data_valid or din changing in the same cycle as reset release: the value present at the first rising edge with rst=1 is used.

Decomposition:
- Shared package: WIDTH default constant (16) and STAGES constant (32).
- Sub-module dff16_en: one WIDTH-bit register with async active-low clear and enable. Ports: clk, rst, en, d, q.
- Top level instantiates 32 copies via generate, chained q→d, with all en inputs tied to data_valid.
- Top level maps the internal stage array onto dout00..dout31.

Test Plan:
Clock period 10 ns, rising edges at 10, 20, 30 …
1. Reset: rst=0 from t=0 to t=5 with din=0x0094 → all 32 outputs 0x0000 during reset, including before the first clock edge.
2. Hold while invalid: rst=1, data_valid=0, din=0xAAAA over edges 10 and 20 → all outputs remain 0x0000.
3. Single pulse propagation:
   - Stimulus: data_valid=1 from t=35; din=0x3333 for one cycle (t=40–50), otherwise 0.
   - dout00=0x3333 after edge 50 and returns to 0 after edge 60.
   - doutK=0x3333 for exactly the cycle after edge 50+10K; dout31 shows it after edge 360.
   - Exactly one output is nonzero at any time.
4. Second pulse in flight:
   - Stimulus: din=0x4444 for t=200–210.
   - dout00=0x4444 after edge 210 while 0x3333 is simultaneously at dout16.
   - The two pulses stay 16 stages apart through the chain.
5. Enable gap:
   - Stimulus: after loading 0x1234 into dout00, drop data_valid for 3 cycles, then restore it.
   - Chain frozen during the gap (dout00=0x1234 held).
   - Next valid edge moves 0x1234 to dout01.
6. Mid-stream reset: pulse rst low asynchronously (between edges) while 0x3333 sits in dout05 → all outputs 0 immediately; no 0x3333 reappears afterwards.

Source files
------------

// File: rtl/dff16_chain31_shift_pkg.sv
// Shared constants for the 32-stage tapped delay line.
// Depth is fixed because every stage has its own enumerated output port.
package dff16_chain31_shift_pkg;

    localparam int DEFAULT_WIDTH = 16;
    localparam int STAGES        = 32;

endpackage

// File: rtl/dff16_chain31_shift_dff16_en.sv
// One WIDTH-bit delay-line stage: async active-low clear, load on enable.
module dff16_en
    import dff16_chain31_shift_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q <= '0;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/dff16_chain31_shift.sv
// 32-stage shift-register delay line; dout00 is the newest sample, dout31 the oldest.
// All stages share one enable, so invalid cycles stretch the delay without losing data.
module dff16_chain31_shift
    import dff16_chain31_shift_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             data_valid,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout00,
    output logic [WIDTH-1:0] dout01,
    output logic [WIDTH-1:0] dout02,
    output logic [WIDTH-1:0] dout03,
    output logic [WIDTH-1:0] dout04,
    output logic [WIDTH-1:0] dout05,
    output logic [WIDTH-1:0] dout06,
    output logic [WIDTH-1:0] dout07,
    output logic [WIDTH-1:0] dout08,
    output logic [WIDTH-1:0] dout09,
    output logic [WIDTH-1:0] dout10,
    output logic [WIDTH-1:0] dout11,
    output logic [WIDTH-1:0] dout12,
    output logic [WIDTH-1:0] dout13,
    output logic [WIDTH-1:0] dout14,
    output logic [WIDTH-1:0] dout15,
    output logic [WIDTH-1:0] dout16,
    output logic [WIDTH-1:0] dout17,
    output logic [WIDTH-1:0] dout18,
    output logic [WIDTH-1:0] dout19,
    output logic [WIDTH-1:0] dout20,
    output logic [WIDTH-1:0] dout21,
    output logic [WIDTH-1:0] dout22,
    output logic [WIDTH-1:0] dout23,
    output logic [WIDTH-1:0] dout24,
    output logic [WIDTH-1:0] dout25,
    output logic [WIDTH-1:0] dout26,
    output logic [WIDTH-1:0] dout27,
    output logic [WIDTH-1:0] dout28,
    output logic [WIDTH-1:0] dout29,
    output logic [WIDTH-1:0] dout30,
    output logic [WIDTH-1:0] dout31
);

    logic [WIDTH-1:0] stage [STAGES];

    // Stage 0 loads din; every later stage loads its predecessor.
    for (genvar i = 0; i < STAGES; i++) begin : g_stage
        if (i == 0) begin : g_head
            dff16_en #(.WIDTH(WIDTH)) u_reg (
                .clk (clk),
                .rst (rst),
                .en  (data_valid),
                .d   (din),
                .q   (stage[i])
            );
        end else begin : g_link
            dff16_en #(.WIDTH(WIDTH)) u_reg (
                .clk (clk),
                .rst (rst),
                .en  (data_valid),
                .d   (stage[i-1]),
                .q   (stage[i])
            );
        end
    end

    assign dout00 = stage[0];
    assign dout01 = stage[1];
    assign dout02 = stage[2];
    assign dout03 = stage[3];
    assign dout04 = stage[4];
    assign dout05 = stage[5];
    assign dout06 = stage[6];
    assign dout07 = stage[7];
    assign dout08 = stage[8];
    assign dout09 = stage[9];
    assign dout10 = stage[10];
    assign dout11 = stage[11];
    assign dout12 = stage[12];
    assign dout13 = stage[13];
    assign dout14 = stage[14];
    assign dout15 = stage[15];
    assign dout16 = stage[16];
    assign dout17 = stage[17];
    assign dout18 = stage[18];
    assign dout19 = stage[19];
    assign dout20 = stage[20];
    assign dout21 = stage[21];
    assign dout22 = stage[22];
    assign dout23 = stage[23];
    assign dout24 = stage[24];
    assign dout25 = stage[25];
    assign dout26 = stage[26];
    assign dout27 = stage[27];
    assign dout28 = stage[28];
    assign dout29 = stage[29];
    assign dout30 = stage[30];
    assign dout31 = stage[31];

endmodule

// File: tb/tb_dff16_chain31_shift.sv
// Directed bench for the 32-stage delay line: reset, hold, pulse propagation,
// two pulses in flight, enable gap and asynchronous mid-stream reset.
module tb_dff16_chain31_shift;

    logic        clk;
    logic        rst;
    logic        data_valid;
    logic [15:0] din;
    logic [15:0] dout [32];
    logic [15:0] exp_q [32];

    int errors = 0;
    int checks = 0;

    dff16_chain31_shift dut (
        .clk        (clk),
        .rst        (rst),
        .data_valid (data_valid),
        .din        (din),
        .dout00 (dout[0]),  .dout01 (dout[1]),  .dout02 (dout[2]),  .dout03 (dout[3]),
        .dout04 (dout[4]),  .dout05 (dout[5]),  .dout06 (dout[6]),  .dout07 (dout[7]),
        .dout08 (dout[8]),  .dout09 (dout[9]),  .dout10 (dout[10]), .dout11 (dout[11]),
        .dout12 (dout[12]), .dout13 (dout[13]), .dout14 (dout[14]), .dout15 (dout[15]),
        .dout16 (dout[16]), .dout17 (dout[17]), .dout18 (dout[18]), .dout19 (dout[19]),
        .dout20 (dout[20]), .dout21 (dout[21]), .dout22 (dout[22]), .dout23 (dout[23]),
        .dout24 (dout[24]), .dout25 (dout[25]), .dout26 (dout[26]), .dout27 (dout[27]),
        .dout28 (dout[28]), .dout29 (dout[29]), .dout30 (dout[30]), .dout31 (dout[31])
    );

    // Rising edges at 10, 20, 30 ...
    initial begin
        clk = 1'b0;
        #5;
        forever #5 clk = ~clk;
    end

    initial begin
        #20000;
        $display("FAIL watchdog: observed timeout expected end of sequence");
        $fatal(1, "simulation timeout");
    end

    task automatic clear_exp();
        for (int i = 0; i < 32; i++) exp_q[i] = 16'h0000;
    endtask

    task automatic check_all(input string tag);
        for (int i = 0; i < 32; i++) begin
            checks++;
            assert (dout[i] === exp_q[i])
            else begin
                errors++;
                $error("FAIL %s dout%0d: observed %h expected %h", tag, i, dout[i], exp_q[i]);
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // 1. reset, checked before any clock edge
        rst = 1'b0; data_valid = 1'b0; din = 16'h0094;
        clear_exp();
        #1;
        check_all("reset_pre_edge");
        #4;
        rst = 1'b1;
        din = 16'hAAAA;

        // 2. hold while invalid (edges 10, 20)
        tick(); check_all("hold_e10");
        tick(); check_all("hold_e20");

        // 3. single pulse: valid from t=35, 0x3333 captured at edge 50
        #14;
        data_valid = 1'b1;
        din = 16'h0000;
        tick();                     // edge 40 shifts a zero in
        check_all("zero_e40");
        din = 16'h3333;
        tick();                     // edge 50
        din = 16'h0000;
        clear_exp(); exp_q[0] = 16'h3333;
        check_all("pulse_k0");
        for (int k = 1; k <= 15; k++) begin
            tick();
            clear_exp(); exp_q[k] = 16'h3333;
            check_all($sformatf("pulse_k%0d", k));
        end
        // 4. second pulse captured at edge 210, 16 stages behind the first
        din = 16'h4444;
        for (int k = 16; k <= 31; k++) begin
            tick();
            din = 16'h0000;
            clear_exp(); exp_q[k] = 16'h3333; exp_q[k-16] = 16'h4444;
            check_all($sformatf("two_pulses_k%0d", k));
        end
        for (int k = 32; k <= 47; k++) begin
            tick();
            clear_exp(); exp_q[k-16] = 16'h4444;
            check_all($sformatf("second_pulse_k%0d", k));
        end
        tick();                     // edge 530: chain drained
        clear_exp();
        check_all("drained_e530");

        // 5. enable gap: load 0x1234, freeze for 3 edges with junk on din
        din = 16'h1234;
        tick();                     // edge 540
        data_valid = 1'b0;
        din = 16'hAAAA;
        clear_exp(); exp_q[0] = 16'h1234;
        check_all("gap_load_e540");
        for (int g = 0; g < 3; g++) begin
            tick();
            check_all($sformatf("gap_hold_%0d", g));
        end
        data_valid = 1'b1;
        din = 16'h0000;
        tick();                     // edge 580
        clear_exp(); exp_q[1] = 16'h1234;
        check_all("gap_resume_e580");

        // 6. mid-stream asynchronous reset with 0x3333 at dout05
        din = 16'h3333;
        tick();                     // edge 590
        din = 16'h0000;
        clear_exp(); exp_q[0] = 16'h3333; exp_q[2] = 16'h1234;
        check_all("reload_e590");
        for (int k = 1; k <= 5; k++) begin
            tick();
            clear_exp(); exp_q[k] = 16'h3333; exp_q[k+2] = 16'h1234;
            check_all($sformatf("reload_k%0d", k));
        end
        #4;                         // t=645, between edges
        rst = 1'b0;
        #1;
        clear_exp();
        check_all("async_reset_now");
        #1;
        check_all("async_reset_held");
        #1;
        rst = 1'b1;
        for (int k = 0; k < 40; k++) begin
            tick();
            check_all($sformatf("post_reset_%0d", k));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
